// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite/life logic.
package pacman_pkg;

  localparam int unsigned COORD_W         = 10;
  localparam int unsigned LIVES_W         = 3;
  localparam int unsigned NUM_GHOSTS      = 4;
  localparam int unsigned DEF_START_LIVES = 3;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HIT       = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } life_state_t;

  // Counter width wide enough for the longer of the two windows, at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sprite_overlap.sv
// Combinational box-overlap test between two sprites given centres and half-sizes.
module sprite_overlap
  import pacman_pkg::*;
(
  input  logic [COORD_W-1:0] aX,
  input  logic [COORD_W-1:0] aY,
  input  logic [COORD_W-1:0] aS,
  input  logic [COORD_W-1:0] bX,
  input  logic [COORD_W-1:0] bY,
  input  logic [COORD_W-1:0] bS,
  input  logic               en,
  input  logic [COORD_W-1:0] slack,
  output logic               hit
);

  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic [COORD_W:0]   w_sum;
  logic [COORD_W:0]   w_lim;

  // Non-wrapping distances and a slack-reduced limit clamped at zero.
  always_comb begin
    w_dx  = (aX >= bX) ? (aX - bX) : (bX - aX);
    w_dy  = (aY >= bY) ? (aY - bY) : (bY - aY);
    w_sum = {1'b0, aS} + {1'b0, bS};
    w_lim = (w_sum > {1'b0, slack}) ? (w_sum - {1'b0, slack}) : '0;
    hit   = en & ({1'b0, w_dx} < w_lim) & ({1'b0, w_dy} < w_lim);
  end

endmodule

// File: rtl/life_manager.sv
// Collision detection, life counting, freeze/invulnerability windows and game over.
module life_manager
  import pacman_pkg::*;
#(
  parameter int unsigned START_LIVES   = DEF_START_LIVES,
  parameter int unsigned FREEZE_FRAMES = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned HIT_SLACK     = 4
) (
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                start,
  input  logic [COORD_W-1:0]  pacX,
  input  logic [COORD_W-1:0]  pacY,
  input  logic [COORD_W-1:0]  pacS,
  input  logic [COORD_W-1:0]  ghost0X,
  input  logic [COORD_W-1:0]  ghost1X,
  input  logic [COORD_W-1:0]  ghost2X,
  input  logic [COORD_W-1:0]  ghost3X,
  input  logic [COORD_W-1:0]  ghost0Y,
  input  logic [COORD_W-1:0]  ghost1Y,
  input  logic [COORD_W-1:0]  ghost2Y,
  input  logic [COORD_W-1:0]  ghost3Y,
  input  logic [COORD_W-1:0]  ghost0S,
  input  logic [COORD_W-1:0]  ghost1S,
  input  logic [COORD_W-1:0]  ghost2S,
  input  logic [COORD_W-1:0]  ghost3S,
  input  logic [3:0]          ghost_en,
  output logic                lifeDown,
  output logic [LIVES_W-1:0]  lives,
  output logic                freeze,
  output logic                invuln,
  output logic                game_over
);

  localparam int unsigned CNT_W = cnt_width(FREEZE_FRAMES, INVULN_FRAMES);

  logic [COORD_W-1:0] w_gx [NUM_GHOSTS];
  logic [COORD_W-1:0] w_gy [NUM_GHOSTS];
  logic [COORD_W-1:0] w_gs [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] w_hit;
  logic                  w_hit_any;

  life_state_t        r_state;
  life_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [LIVES_W-1:0] r_lives;
  logic [LIVES_W-1:0] w_lives_nxt;
  logic               r_life_down;
  logic               w_life_down_nxt;
  logic               r_freeze;
  logic               w_freeze_nxt;
  logic               r_invuln;
  logic               w_invuln_nxt;
  logic               r_game_over;
  logic               w_game_over_nxt;

  assign w_gx = '{ghost0X, ghost1X, ghost2X, ghost3X};
  assign w_gy = '{ghost0Y, ghost1Y, ghost2Y, ghost3Y};
  assign w_gs = '{ghost0S, ghost1S, ghost2S, ghost3S};

  // One overlap checker per ghost.
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_overlap
    sprite_overlap u_overlap (
      .aX    (pacX),
      .aY    (pacY),
      .aS    (pacS),
      .bX    (w_gx[g]),
      .bY    (w_gy[g]),
      .bS    (w_gs[g]),
      .en    (ghost_en[g]),
      .slack (COORD_W'(HIT_SLACK)),
      .hit   (w_hit[g])
    );
  end

  // Simultaneous hits collapse to a single event.
  assign w_hit_any = |w_hit;

  // State, counter and registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= PLAY;
      r_cnt       <= '0;
      r_lives     <= LIVES_W'(START_LIVES);
      r_life_down <= 1'b0;
      r_freeze    <= 1'b0;
      r_invuln    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lives     <= w_lives_nxt;
      r_life_down <= w_life_down_nxt;
      r_freeze    <= w_freeze_nxt;
      r_invuln    <= w_invuln_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  // Next state and window counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      PLAY: begin
        if (w_hit_any) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_lives <= LIVES_W'(1)) ? GAME_OVER : HIT;
        end
      end
      HIT: begin
        if (r_cnt == CNT_W'(FREEZE_FRAMES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RESPAWN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RESPAWN: begin
        if (r_cnt == CNT_W'(INVULN_FRAMES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = PLAY;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GAME_OVER: begin
        if (start) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RESPAWN;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = PLAY;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the transition.
  always_comb begin
    w_life_down_nxt = (r_state == PLAY) && w_hit_any;
    w_lives_nxt     = r_lives;
    if (w_life_down_nxt && (r_lives != '0)) begin
      w_lives_nxt = r_lives - LIVES_W'(1);
    end else if ((r_state == GAME_OVER) && start) begin
      w_lives_nxt = LIVES_W'(START_LIVES);
    end
    w_freeze_nxt    = (w_state_nxt == HIT) || (w_state_nxt == GAME_OVER);
    w_invuln_nxt    = (w_state_nxt == RESPAWN);
    w_game_over_nxt = (w_state_nxt == GAME_OVER);
  end

  assign lifeDown  = r_life_down;
  assign lives     = r_lives;
  assign freeze    = r_freeze;
  assign invuln    = r_invuln;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_life_manager.sv
// Directed bench for life_manager: hits, windows, boundaries, game over, async reset.
module tb_life_manager;
  import pacman_pkg::*;

  logic       Reset, frame_clk, start;
  logic [9:0] pacX, pacY, pacS;
  logic [9:0] ghost0X, ghost1X, ghost2X, ghost3X;
  logic [9:0] ghost0Y, ghost1Y, ghost2Y, ghost3Y;
  logic [9:0] ghost0S, ghost1S, ghost2S, ghost3S;
  logic [3:0] ghost_en;
  logic       lifeDown, freeze, invuln, game_over;
  logic [2:0] lives;

  int total = 0;
  int bad   = 0;

  life_manager dut (
    .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .pacX(pacX), .pacY(pacY), .pacS(pacS),
    .ghost0X(ghost0X), .ghost1X(ghost1X), .ghost2X(ghost2X), .ghost3X(ghost3X),
    .ghost0Y(ghost0Y), .ghost1Y(ghost1Y), .ghost2Y(ghost2Y), .ghost3Y(ghost3Y),
    .ghost0S(ghost0S), .ghost1S(ghost1S), .ghost2S(ghost2S), .ghost3S(ghost3S),
    .ghost_en(ghost_en),
    .lifeDown(lifeDown), .lives(lives), .freeze(freeze), .invuln(invuln),
    .game_over(game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge frame_clk);
  endtask

  task automatic set_ghost(input int idx, input int x, input int y);
    case (idx)
      0: begin ghost0X = 10'(x); ghost0Y = 10'(y); end
      1: begin ghost1X = 10'(x); ghost1Y = 10'(y); end
      2: begin ghost2X = 10'(x); ghost2Y = 10'(y); end
      default: begin ghost3X = 10'(x); ghost3Y = 10'(y); end
    endcase
  endtask

  task automatic park_ghosts();
    for (int i = 0; i < 4; i++) set_ghost(i, 144, 165);
    ghost0S = 10'd13; ghost1S = 10'd13; ghost2S = 10'd13; ghost3S = 10'd13;
  endtask

  task automatic do_reset();
    Reset = 1'b1; start = 1'b0;
    pacX = 10'd300; pacY = 10'd400; pacS = 10'd13;
    park_ghosts();
    ghost_en = 4'hF;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // Waits until both windows close; an expired bound is a failure.
  task automatic wait_clear();
    int n;
    n = 0;
    while ((freeze || invuln) && n < 300) begin n++; tick(); end
    total++;
    if (n >= 300) begin bad++; $display("FAIL wait_clear: windows still open after %0d frames", n); end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0;
    pacX = 10'd300; pacY = 10'd400; pacS = 10'd13;
    park_ghosts();
    ghost_en = 4'hF;
    #1;
    total++;
    if (lives !== 3'd3 || lifeDown !== 1'b0 || freeze !== 1'b0 || invuln !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL reset_values: lives=%0d ld=%0b fr=%0b inv=%0b go=%0b want 3 0 0 0 0",
                      lives, lifeDown, freeze, invuln, game_over);
    end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (lives !== 3'd3 || lifeDown !== 1'b0 || freeze !== 1'b0 || invuln !== 1'b0) begin
        bad++; $display("FAIL idle_frame%0d: lives=%0d ld=%0b fr=%0b inv=%0b want 3 0 0 0",
                        i, lives, lifeDown, freeze, invuln);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (lives !== 3'd3 || invuln !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL start_in_play: lives=%0d inv=%0b go=%0b want 3 0 0", lives, invuln, game_over);
    end
  endtask

  task automatic test_hit_window();
    int n_fr, n_inv, extra_ld;
    do_reset();
    set_ghost(0, 310, 400);
    tick();
    total++;
    if (lifeDown !== 1'b1 || lives !== 3'd2 || freeze !== 1'b1 || invuln !== 1'b0) begin
      bad++; $display("FAIL first_hit: ld=%0b lives=%0d fr=%0b inv=%0b want 1 2 1 0",
                      lifeDown, lives, freeze, invuln);
    end
    n_fr = 0; extra_ld = 0;
    while (freeze && n_fr < 200) begin
      n_fr++; tick();
      if (lifeDown) extra_ld++;
    end
    total++;
    if (n_fr !== 60) begin bad++; $display("FAIL freeze_len: got %0d want 60", n_fr); end
    total++;
    if (invuln !== 1'b1) begin bad++; $display("FAIL invuln_start: got %0b want 1", invuln); end
    n_inv = 0;
    while (invuln && n_inv < 300) begin
      n_inv++; tick();
      if (lifeDown) extra_ld++;
    end
    total++;
    if (n_inv !== 120) begin bad++; $display("FAIL invuln_len: got %0d want 120", n_inv); end
    total++;
    if (extra_ld !== 0 || lives !== 3'd2 || freeze !== 1'b0) begin
      bad++; $display("FAIL window_ignore: extra_ld=%0d lives=%0d fr=%0b want 0 2 0", extra_ld, lives, freeze);
    end
    tick();
    total++;
    if (lifeDown !== 1'b1 || lives !== 3'd1 || freeze !== 1'b1) begin
      bad++; $display("FAIL first_play_edge_hit: ld=%0b lives=%0d fr=%0b want 1 1 1", lifeDown, lives, freeze);
    end
    tick();
    total++;
    if (lifeDown !== 1'b0) begin bad++; $display("FAIL pulse_width: ld=%0b want 0", lifeDown); end
  endtask

  task automatic test_multi_hit();
    do_reset();
    set_ghost(0, 310, 400);
    set_ghost(2, 295, 405);
    tick();
    total++;
    if (lifeDown !== 1'b1 || lives !== 3'd2) begin
      bad++; $display("FAIL multi_hit: ld=%0b lives=%0d want 1 2", lifeDown, lives);
    end
    tick();
    total++;
    if (lifeDown !== 1'b0 || lives !== 3'd2) begin
      bad++; $display("FAIL multi_hit_once: ld=%0b lives=%0d want 0 2", lifeDown, lives);
    end
  endtask

  task automatic test_enable_boundary();
    do_reset();
    ghost_en = 4'b1110;
    set_ghost(0, 310, 400);
    repeat (3) tick();
    total++;
    if (lifeDown !== 1'b0 || lives !== 3'd3) begin
      bad++; $display("FAIL disabled_ghost: ld=%0b lives=%0d want 0 3", lifeDown, lives);
    end
    ghost_en = 4'hF;
    set_ghost(0, 322, 400);
    set_ghost(1, 300, 378);
    tick();
    total++;
    if (lifeDown !== 1'b0 || lives !== 3'd3) begin
      bad++; $display("FAIL dx22_dy22_edge: ld=%0b lives=%0d want 0 3", lifeDown, lives);
    end
    set_ghost(1, 144, 165);
    set_ghost(0, 279, 400);
    tick();
    total++;
    if (lifeDown !== 1'b1 || lives !== 3'd2) begin
      bad++; $display("FAIL dx21_edge: ld=%0b lives=%0d want 1 2", lifeDown, lives);
    end
  endtask

  task automatic test_game_over();
    int n_inv, extra_ld;
    do_reset();
    for (int h = 0; h < 3; h++) begin
      set_ghost(0, 310, 400);
      tick();
      total++;
      if (lifeDown !== 1'b1 || lives !== 3'(2 - h)) begin
        bad++; $display("FAIL hit%0d: ld=%0b lives=%0d want 1 %0d", h, lifeDown, lives, 2 - h);
      end
      if (h < 2) begin
        set_ghost(0, 144, 165);
        wait_clear();
        tick();
      end
    end
    total++;
    if (game_over !== 1'b1 || freeze !== 1'b1 || invuln !== 1'b0) begin
      bad++; $display("FAIL go_enter: go=%0b fr=%0b inv=%0b want 1 1 0", game_over, freeze, invuln);
    end
    extra_ld = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (lifeDown) extra_ld++;
    end
    total++;
    if (game_over !== 1'b1 || freeze !== 1'b1 || invuln !== 1'b0 || lives !== 3'd0 || extra_ld !== 0) begin
      bad++; $display("FAIL go_hold: go=%0b fr=%0b inv=%0b lives=%0d extra_ld=%0d want 1 1 0 0 0",
                      game_over, freeze, invuln, lives, extra_ld);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (lives !== 3'd3 || game_over !== 1'b0 || freeze !== 1'b0 || invuln !== 1'b1 || lifeDown !== 1'b0) begin
      bad++; $display("FAIL restart: lives=%0d go=%0b fr=%0b inv=%0b ld=%0b want 3 0 0 1 0",
                      lives, game_over, freeze, invuln, lifeDown);
    end
    n_inv = 0; extra_ld = 0;
    while (invuln && n_inv < 300) begin
      n_inv++; tick();
      if (lifeDown) extra_ld++;
    end
    total++;
    if (n_inv !== 120 || extra_ld !== 0 || lives !== 3'd3) begin
      bad++; $display("FAIL restart_invuln: len=%0d extra_ld=%0d lives=%0d want 120 0 3", n_inv, extra_ld, lives);
    end
  endtask

  task automatic test_reset_mid_hit();
    do_reset();
    set_ghost(0, 310, 400);
    tick();
    set_ghost(0, 144, 165);
    repeat (30) tick();
    total++;
    if (freeze !== 1'b1 || lives !== 3'd2) begin
      bad++; $display("FAIL mid_hit_pre: fr=%0b lives=%0d want 1 2", freeze, lives);
    end
    #1;
    Reset = 1'b1;
    #1;
    total++;
    if (freeze !== 1'b0 || lives !== 3'd3 || invuln !== 1'b0 || lifeDown !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL async_reset: fr=%0b lives=%0d inv=%0b ld=%0b go=%0b want 0 3 0 0 0",
                      freeze, lives, invuln, lifeDown, game_over);
    end
    total++;
    if (dut.r_state !== PLAY) begin
      bad++; $display("FAIL async_reset_state: got %0d want %0d", dut.r_state, PLAY);
    end
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_hit_window();
    test_multi_hit();
    test_enable_boundary();
    test_game_over();
    test_reset_mid_hit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
